dispense_cmd_tx: RTL and testbench
==================================

DISPENSE_CMD_TX -- requirements
Module: dispense_cmd_tx

Interface
REQ-001 The module SHALL have parameter SETUP_CYCLES, default 4: cycles the command bus is held stable before candyflag_o rises; legal range 1..255.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 2080000 (1 s at 2.08 MHz): the bound on every wait state; legal range 2..2^24-1.
REQ-003 The module SHALL have a single clock and a synchronous, active-high reset, with ports exactly as follows:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  module idle, can accept a command.
- cmd_state  in  3  motion state code to drive.
- cmd_amount  in  2  dispense amount code.
- cmd_dispense  in  1  1 = dispense command (flag/handshake), 0 = motion-only.
- handshake_i  in  1  asynchronous acknowledge from the dispenser.
- teststate_o  out  3  registered motion-state bus.
- amount_o  out  2  registered amount bus.
- candyflag_o  out  1  registered dispense request.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  2  completion code, valid when done_o=1: 00 ok, 01 ack timeout, 10 release timeout, 11 invalid amount.
- busy_o  out  1  FSM not in IDLE.

Function
REQ-004 handshake_i SHALL pass through a 2-flop synchronizer before use (sync_ack); FSM decisions SHALL use sync_ack only.
REQ-005 The FSM SHALL have exactly the states IDLE, SETUP, WAIT_ACK and WAIT_REL.
REQ-006 cmd_ready SHALL equal (state==IDLE) and not rst; busy_o SHALL equal (state!=IDLE).
REQ-007 Accept: a command is accepted on the edge where cmd_valid and cmd_ready are both 1; cmd_* inputs are ignored at all other times.
REQ-008 Accept of a dispense command with cmd_amount=11: bus and flag SHALL be unchanged, state SHALL stay IDLE, and the next cycle SHALL show done_o=1 with status 11.
REQ-009 Any other accept: on the next cycle teststate_o=cmd_state, amount_o=cmd_amount and state=SETUP, and the cycle counter SHALL be cleared.
REQ-010 SETUP exits once the counter reaches SETUP_CYCLES and sync_ack=0:
- motion-only command: to IDLE, with done_o=1 and status 00 in the following cycle;
- dispense command: to WAIT_ACK, with candyflag_o=1 in the following cycle; the counter SHALL be cleared.
REQ-011 If sync_ack stays 1 for TIMEOUT_CYCLES cycles in SETUP (stale ack), the FSM SHALL go to IDLE with status 10, teststate_o=000 and amount_o=00, and SHALL NOT raise candyflag_o.
REQ-012 WAIT_ACK, on sync_ack=1: candyflag_o SHALL go to 0 in the next cycle, the state SHALL become WAIT_REL and the counter SHALL be cleared.
REQ-013 WAIT_ACK, after TIMEOUT_CYCLES cycles without sync_ack: candyflag_o=0, teststate_o=000 (stop), amount_o=00, and IDLE with done_o=1 and status 01.
REQ-014 WAIT_REL, on sync_ack=0: IDLE with done_o=1 and status 00.
REQ-015 WAIT_REL, after TIMEOUT_CYCLES cycles with sync_ack=1: IDLE with status 10, teststate_o=000 and amount_o=00.
REQ-016 After an ok completion, teststate_o and amount_o SHALL hold their last values until the next accept; candyflag_o SHALL be 0 whenever state!=WAIT_ACK.
REQ-017 done_o SHALL be exactly one cycle wide, at most once per accepted command; status_o SHALL hold its last value between pulses.
REQ-018 The counter SHALL saturate and never wrap; its width SHALL be the minimum needed to represent TIMEOUT_CYCLES.
REQ-019 No output SHALL change combinationally from handshake_i.

Reset
REQ-020 While rst=1 at a clock edge, the module SHALL set state=IDLE, teststate_o=000, amount_o=00, candyflag_o=0, done_o=0, status_o=00, the counter=0 and the synchronizer flops=0.
REQ-021 Reset mid-transaction SHALL abort it immediately, with no done_o pulse; candyflag_o SHALL be 0 in the first cycle after the reset edge.
REQ-022 cmd_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.

Verification
REQ-023 Motion command (SETUP_CYCLES=4): cmd_state=011, dispense=0 -> teststate_o=011 one cycle after accept, done_o with status 00 six cycles after accept, candyflag_o never rises.
REQ-024 Dispense command: cmd_amount=01; bench raises handshake_i 10 cycles after candyflag_o rises and drops it 5 cycles after candyflag_o falls -> candyflag_o falls 3 cycles after handshake_i rises, done_o with status 00 three cycles after handshake_i falls.
REQ-025 Ack timeout (TIMEOUT_CYCLES=20): no handshake -> candyflag_o high 20 cycles, then candyflag_o=0, teststate_o=000, done_o with status 01.
REQ-026 Invalid amount and stale ack:
- cmd_amount=11 with dispense=1 -> done_o with status 11 one cycle after accept, bus unchanged;
- handshake_i held high from before accept -> no flag, status 10 after TIMEOUT_CYCLES.
REQ-027 Reset during WAIT_ACK -> candyflag_o=0, all outputs at reset values, no done_o; a new command is accepted on the first cycle after rst falls.
REQ-028 Back-to-back accepts: cmd_valid held high -> the second command is accepted on the cycle done_o pulses and none is lost or duplicated.

Source files
------------

// File: rtl/dispense_cmd_tx.sv
// dispense_cmd_tx
//   Drives a motion-state / amount command bus toward a candy dispenser and,
//   for dispense commands, runs a flag/acknowledge handshake:
//     bus set -> hold SETUP_CYCLES -> raise candyflag -> wait ack -> drop flag
//     -> wait ack release -> done.
//   Every wait state is bounded by TIMEOUT_CYCLES; a timeout parks the bus at
//   stop (000 / 00) and reports an error code on status_o.
//
// Ports
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   cmd_valid/ready: command handshake (accepted when both are 1)
//   cmd_state      : motion state code, cmd_amount: amount code,
//   cmd_dispense   : 1 = dispense (flag/handshake), 0 = motion-only
//   handshake_i    : asynchronous acknowledge from the dispenser
//   teststate_o    : registered motion-state bus
//   amount_o       : registered amount bus
//   candyflag_o    : registered dispense request
//   done_o         : one-cycle completion pulse
//   status_o       : 00 ok, 01 ack timeout, 10 release timeout, 11 bad amount
//   busy_o         : FSM not idle
module dispense_cmd_tx #(
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2080000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_state,
    input  logic [1:0] cmd_amount,
    input  logic       cmd_dispense,
    input  logic       handshake_i,
    output logic [2:0] teststate_o,
    output logic [1:0] amount_o,
    output logic       candyflag_o,
    output logic       done_o,
    output logic [1:0] status_o,
    output logic       busy_o
);

    // The counter also times the setup hold, so it must cover SETUP_CYCLES
    // should that ever exceed TIMEOUT_CYCLES; normally TIMEOUT dominates.
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ?
                                      TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LIM = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ACK_TO  = 2'b01;
    localparam logic [1:0] ST_REL_TO  = 2'b10;
    localparam logic [1:0] ST_BAD_AMT = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]    teststate_q, teststate_d;
    logic [1:0]    amount_q, amount_d;
    logic          candyflag_q, candyflag_d;
    logic          done_q, done_d;
    logic [1:0]    status_q, status_d;
    logic          dispense_q, dispense_d;
    logic          sync1_q, sync1_d;
    logic          sync_ack_q, sync_ack_d;

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign busy_o      = (state_q != IDLE);
    assign teststate_o = teststate_q;
    assign amount_o    = amount_q;
    assign candyflag_o = candyflag_q;
    assign done_o      = done_q;
    assign status_o    = status_q;

    always_comb begin
        sync1_d     = handshake_i;
        sync_ack_d  = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        teststate_d = teststate_q;
        amount_d    = amount_q;
        candyflag_d = candyflag_q;
        done_d      = 1'b0;
        status_d    = status_q;
        dispense_d  = dispense_q;
        cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_dispense && (cmd_amount == 2'b11)) begin
                        // Rejected in place: bus untouched, stay idle.
                        done_d   = 1'b1;
                        status_d = ST_BAD_AMT;
                    end else begin
                        teststate_d = cmd_state;
                        amount_d    = cmd_amount;
                        dispense_d  = cmd_dispense;
                        cnt_d       = '0;
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                if (sync_ack_q && (cnt_q >= TO_LIM)) begin
                    // Ack never released since before the command: give up
                    // without ever raising the flag.
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    status_d    = ST_REL_TO;
                    teststate_d = '0;
                    amount_d    = '0;
                end else if (!sync_ack_q && (cnt_q >= SETUP_LIM)) begin
                    if (dispense_q) begin
                        state_d     = WAIT_ACK;
                        candyflag_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        status_d = ST_OK;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_ACK: begin
                if (sync_ack_q) begin
                    candyflag_d = 1'b0;
                    state_d     = WAIT_REL;
                    cnt_d       = '0;
                end else if (cnt_q >= TO_LIM) begin
                    candyflag_d = 1'b0;
                    teststate_d = '0;
                    amount_d    = '0;
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    status_d    = ST_ACK_TO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_REL: begin
                if (!sync_ack_q) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    status_d = ST_OK;
                end else if (cnt_q >= TO_LIM) begin
                    teststate_d = '0;
                    amount_d    = '0;
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    status_d    = ST_REL_TO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            teststate_q <= '0;
            amount_q    <= '0;
            candyflag_q <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= '0;
            dispense_q  <= 1'b0;
            sync1_q     <= 1'b0;
            sync_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            teststate_q <= teststate_d;
            amount_q    <= amount_d;
            candyflag_q <= candyflag_d;
            done_q      <= done_d;
            status_q    <= status_d;
            dispense_q  <= dispense_d;
            sync1_q     <= sync1_d;
            sync_ack_q  <= sync_ack_d;
        end
    end

endmodule

// File: tb/tb_dispense_cmd_tx.sv
// tb_dispense_cmd_tx
//   Open-loop directed bench. Expected output waveforms are painted per cycle
//   from transaction-level timing rules (accept cycle + fixed latencies), and
//   one process compares every output against them each cycle. A few literal
//   point checks pin the painted timeline.
//   Cycle c is the interval after the c-th rising edge; inputs are driven 1
//   time unit after the edge, outputs are compared on the falling edge.
module tb_dispense_cmd_tx;

    localparam int unsigned SETUP = 4;
    localparam int unsigned TMO   = 20;
    localparam int NCYC = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_state = '0;
    logic [1:0] cmd_amount = '0;
    logic       cmd_dispense = 1'b0;
    logic       handshake_i = 1'b0;
    logic [2:0] teststate_o;
    logic [1:0] amount_o;
    logic       candyflag_o;
    logic       done_o;
    logic [1:0] status_o;
    logic       busy_o;

    dispense_cmd_tx #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_state(cmd_state), .cmd_amount(cmd_amount),
        .cmd_dispense(cmd_dispense), .handshake_i(handshake_i),
        .teststate_o(teststate_o), .amount_o(amount_o),
        .candyflag_o(candyflag_o), .done_o(done_o),
        .status_o(status_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle waveforms
    logic [2:0] e_ts   [NCYC];
    logic [1:0] e_amt  [NCYC];
    logic       e_flag [NCYC];
    logic       e_done [NCYC];
    logic [1:0] e_stat [NCYC];
    logic       e_busy [NCYC];
    logic       e_rst  [NCYC];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Painters: a value holds from cycle c until repainted later.
    function automatic void p_bus(input int c, input int ts, input int amt);
        for (int i = c; i < NCYC; i++) begin
            e_ts[i]  = 3'(ts);
            e_amt[i] = 2'(amt);
        end
    endfunction
    function automatic void p_flag(input int c, input logic v);
        for (int i = c; i < NCYC; i++) e_flag[i] = v;
    endfunction
    function automatic void p_busy(input int c, input logic v);
        for (int i = c; i < NCYC; i++) e_busy[i] = v;
    endfunction
    function automatic void p_done(input int c, input int st);
        e_done[c] = 1'b1;
        for (int i = c; i < NCYC; i++) e_stat[i] = 2'(st);
    endfunction

    // Transaction models (a = cycle in which cmd_valid is presented and accepted)
    function automatic void m_motion(input int a, input int ts, input int amt);
        p_bus(a + 1, ts, amt);
        p_busy(a + 1, 1'b1);
        p_done(a + 2 + SETUP, 0);
        p_busy(a + 2 + SETUP, 1'b0);
    endfunction

    // Flag rises SETUP+2 after accept; sync + decision costs 3 cycles.
    function automatic void m_disp_ack(input int a, input int ts, input int amt,
                                       input int hs_rise, input int hs_fall);
        p_bus(a + 1, ts, amt);
        p_busy(a + 1, 1'b1);
        p_flag(a + 2 + SETUP, 1'b1);
        p_flag(hs_rise + 3, 1'b0);
        p_done(hs_fall + 3, 0);
        p_busy(hs_fall + 3, 1'b0);
    endfunction

    function automatic void m_disp_timeout(input int a, input int ts, input int amt);
        int r = a + 2 + SETUP;
        p_bus(a + 1, ts, amt);
        p_busy(a + 1, 1'b1);
        p_flag(r, 1'b1);
        p_flag(r + TMO, 1'b0);
        p_bus(r + TMO, 0, 0);
        p_done(r + TMO, 1);
        p_busy(r + TMO, 1'b0);
    endfunction

    function automatic void m_stale(input int a, input int ts, input int amt);
        p_bus(a + 1, ts, amt);
        p_busy(a + 1, 1'b1);
        p_bus(a + 1 + TMO, 0, 0);
        p_done(a + 1 + TMO, 2);
        p_busy(a + 1 + TMO, 1'b0);
    endfunction

    // Reset asserted during cycle x takes effect in cycle x+1.
    function automatic void m_reset(input int x);
        e_rst[x] = 1'b1;
        p_bus(x + 1, 0, 0);
        p_flag(x + 1, 1'b0);
        p_busy(x + 1, 1'b0);
        for (int i = x + 1; i < NCYC; i++) e_stat[i] = 2'b00;
    endfunction

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic v, input int ts, input int amt, input logic d);
        cmd_valid    = v;
        cmd_state    = 3'(ts);
        cmd_amount   = 2'(amt);
        cmd_dispense = d;
    endtask

    // Per-cycle comparison against the painted model
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC) begin
            check("ready",  int'(cmd_ready),   int'(!e_busy[cyc] && !e_rst[cyc]));
            check("busy",   int'(busy_o),      int'(e_busy[cyc]));
            check("ts",     int'(teststate_o), int'(e_ts[cyc]));
            check("amt",    int'(amount_o),    int'(e_amt[cyc]));
            check("flag",   int'(candyflag_o), int'(e_flag[cyc]));
            check("done",   int'(done_o),      int'(e_done[cyc]));
            check("status", int'(status_o),    int'(e_stat[cyc]));
        end
    end

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            e_ts[i] = '0; e_amt[i] = '0; e_flag[i] = 1'b0; e_done[i] = 1'b0;
            e_stat[i] = '0; e_busy[i] = 1'b0; e_rst[i] = (i < 3);
        end
        // Scenario timeline
        m_motion(6, 3'b011, 2'b10);
        m_disp_ack(20, 3'b101, 2'b01, 36, 44);
        p_done(51, 3);                          // invalid amount at 50
        m_disp_timeout(55, 3'b010, 2'b10);
        m_stale(92, 3'b110, 2'b01);
        m_motion(120, 3'b001, 2'b00);           // back-to-back pair
        m_motion(126, 3'b100, 2'b11);
        m_disp_ack(140, 3'b011, 2'b01, 160, 170); // handshake never comes
        m_reset(150);
        for (int i = 151; i < NCYC; i++) e_done[i] = 1'b0;
        m_motion(151, 3'b010, 2'b10);

        // Reset: rst sampled high on edges 1..3
        at(3); rst = 1'b0;

        // Motion command
        at(6);  cmd(1'b1, 3'b011, 2'b10, 1'b0);
        at(7);  cmd_valid = 1'b0;
        #2 check("pin_motion_ts", int'(teststate_o), 3);
        at(12); #2 check("pin_motion_done", int'(done_o), 1);

        // Dispense with handshake: flag rises at 26, ack 10 cycles later,
        // release 5 cycles after the flag falls (39)
        at(20); cmd(1'b1, 3'b101, 2'b01, 1'b1);
        at(21); cmd_valid = 1'b0;
        at(26); #2 check("pin_flag_rise", int'(candyflag_o), 1);
        at(36); handshake_i = 1'b1;
        at(39); #2 check("pin_flag_fall", int'(candyflag_o), 0);
        at(44); handshake_i = 1'b0;
        at(47); #2 check("pin_ack_done", int'(done_o), 1);

        // Invalid amount: bus stays 101/01
        at(50); cmd(1'b1, 3'b111, 2'b11, 1'b1);
        at(51); cmd_valid = 1'b0;
        #2 check("pin_bad_status", int'(status_o), 3);
        check("pin_bad_bus", int'(teststate_o), 5);

        // Ack timeout
        at(55); cmd(1'b1, 3'b010, 2'b10, 1'b1);
        at(56); cmd_valid = 1'b0;
        at(80); #2 check("pin_to_flag_last", int'(candyflag_o), 1);
        at(81); #2 check("pin_to_status", int'(status_o), 1);

        // Stale ack held from before accept
        at(88); handshake_i = 1'b1;
        at(92); cmd(1'b1, 3'b110, 2'b01, 1'b1);
        at(93); cmd_valid = 1'b0;
        at(113); #2 check("pin_stale_status", int'(status_o), 2);
        at(114); handshake_i = 1'b0;

        // Back-to-back with cmd_valid held high
        at(120); cmd(1'b1, 3'b001, 2'b00, 1'b0);
        at(121); cmd(1'b1, 3'b100, 2'b11, 1'b0);
        at(127); cmd_valid = 1'b0;
        #2 check("pin_b2b_ts", int'(teststate_o), 4);

        // Reset during WAIT_ACK, then immediate new command
        at(140); cmd(1'b1, 3'b011, 2'b01, 1'b1);
        at(141); cmd_valid = 1'b0;
        at(150); rst = 1'b1;
        at(151); rst = 1'b0;
        cmd(1'b1, 3'b010, 2'b10, 1'b0);
        #2 check("pin_rst_flag", int'(candyflag_o), 0);
        check("pin_rst_ready", int'(cmd_ready), 1);
        at(152); cmd_valid = 1'b0;
        at(157); #2 check("pin_post_rst_done", int'(done_o), 1);

        at(NCYC - 2);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
